// File: rtl/execute_mul_pkg.sv
// rtl/execute_mul_pkg.sv - shared types and multiply helpers for the execute_mul slice
package execute_mul_pkg;
    localparam int XLEN              = 32;
    localparam int ROB_ID_WIDTH      = 5;
    localparam int ARCH_REG_ID_WIDTH = 5;
    localparam int PHY_REG_ID_WIDTH  = 6;

    typedef enum logic [3:0] {
        alu_add, alu_sub, alu_sll, alu_slt, alu_sltu, alu_xor, alu_srl, alu_sra, alu_or, alu_and
    } alu_op_t;

    typedef enum logic [3:0] {
        mul, mulh, mulhsu, mulhu
    } mul_op_t;

    // Each execute unit reads the view of sub_op that matches its own opcode family.
    typedef union packed {
        alu_op_t alu_op;
        mul_op_t mul_op;
    } sub_op_t;

    typedef enum logic [4:0] {
        instruction_address_misaligned = 5'd0,
        instruction_access_fault       = 5'd1,
        illegal_instruction            = 5'd2,
        breakpoint                     = 5'd3,
        load_address_misaligned        = 5'd4
    } riscv_exception_t;

    typedef struct packed {
        logic                         enable;
        logic                         valid;
        logic [ROB_ID_WIDTH-1:0]      rob_id;
        logic [XLEN-1:0]              pc;
        logic [ARCH_REG_ID_WIDTH-1:0] rd;
        logic                         rd_enable;
        logic                         need_rename;
        logic [PHY_REG_ID_WIDTH-1:0]  rd_phy;
        logic [XLEN-1:0]              src1_value;
        logic [XLEN-1:0]              src2_value;
        sub_op_t                      sub_op;
        logic                         has_exception;
        riscv_exception_t             exception_id;
        logic [XLEN-1:0]              exception_value;
    } issue_execute_pack_t;

    typedef struct packed {
        logic                         enable;
        logic                         valid;
        logic [ROB_ID_WIDTH-1:0]      rob_id;
        logic [XLEN-1:0]              pc;
        logic [ARCH_REG_ID_WIDTH-1:0] rd;
        logic                         rd_enable;
        logic                         need_rename;
        logic [PHY_REG_ID_WIDTH-1:0]  rd_phy;
        logic [XLEN-1:0]              rd_value;
        logic                         has_exception;
        riscv_exception_t             exception_id;
        logic [XLEN-1:0]              exception_value;
    } execute_wb_pack_t;

    typedef struct packed {
        logic                        enable;
        logic [PHY_REG_ID_WIDTH-1:0] phy_id;
        logic [XLEN-1:0]             value;
    } execute_feedback_channel_t;

    typedef struct packed {
        logic enable;
        logic flush;
    } commit_feedback_pack_t;

    // Writeback fields minus rd_value, plus the full product; rd_value is picked at the last stage.
    typedef struct packed {
        logic                         valid;
        logic [ROB_ID_WIDTH-1:0]      rob_id;
        logic [XLEN-1:0]              pc;
        logic [ARCH_REG_ID_WIDTH-1:0] rd;
        logic                         rd_enable;
        logic                         need_rename;
        logic [PHY_REG_ID_WIDTH-1:0]  rd_phy;
        logic                         has_exception;
        riscv_exception_t             exception_id;
        logic [XLEN-1:0]              exception_value;
        mul_op_t                      sub_op;
        logic [2*XLEN-1:0]            product;
    } mul_stage_pack_t;

    // Extending both operands to 2*XLEN makes one unsigned multiply exact for every signedness mix.
    function automatic logic [2*XLEN-1:0] mul_product(mul_op_t op, logic [XLEN-1:0] a,
                                                      logic [XLEN-1:0] b);
        logic              a_signed;
        logic              b_signed;
        logic [2*XLEN-1:0] a_ext;
        logic [2*XLEN-1:0] b_ext;
        a_signed = (op == mulh) || (op == mulhsu);
        b_signed = (op == mulh);
        a_ext    = {{XLEN{a_signed & a[XLEN-1]}}, a};
        b_ext    = {{XLEN{b_signed & b[XLEN-1]}}, b};
        return a_ext * b_ext;
    endfunction

    function automatic logic [XLEN-1:0] mul_select(mul_op_t op, logic [2*XLEN-1:0] product);
        return (op == mul) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];
    endfunction
endpackage

// File: rtl/execute_mul_if.sv
// rtl/execute_mul_if.sv - issue FIFO, writeback, feedback and commit signals of execute_mul
interface execute_mul_if import execute_mul_pkg::*; ();
    issue_execute_pack_t       issue_mul_fifo_data_out;
    logic                      issue_mul_fifo_data_out_valid;
    logic                      issue_mul_fifo_pop;
    execute_wb_pack_t          mul_wb_port_data_in;
    logic                      mul_wb_port_we;
    logic                      mul_wb_port_full;
    logic                      mul_wb_port_flush;
    execute_feedback_channel_t mul_execute_channel_feedback_pack;
    commit_feedback_pack_t     commit_feedback_pack;

    modport master (
        input  issue_mul_fifo_data_out,
        input  issue_mul_fifo_data_out_valid,
        output issue_mul_fifo_pop,
        output mul_wb_port_data_in,
        output mul_wb_port_we,
        input  mul_wb_port_full,
        output mul_wb_port_flush,
        output mul_execute_channel_feedback_pack,
        input  commit_feedback_pack
    );

    modport slave (
        output issue_mul_fifo_data_out,
        output issue_mul_fifo_data_out_valid,
        input  issue_mul_fifo_pop,
        input  mul_wb_port_data_in,
        input  mul_wb_port_we,
        output mul_wb_port_full,
        input  mul_wb_port_flush,
        input  mul_execute_channel_feedback_pack,
        output commit_feedback_pack
    );
endinterface

// File: rtl/execute_mul_stage.sv
// rtl/execute_mul_stage.sv - one stall-able multiply pipeline register with occupied bit
module execute_mul_stage import execute_mul_pkg::*; (
    input  logic            clk,
    input  logic            rst,
    input  logic            advance,
    input  logic            clear,
    input  logic            in_occupied,
    input  mul_stage_pack_t in_pack,
    output logic            out_occupied,
    output mul_stage_pack_t out_pack
);
    logic            occupied_d;
    logic            occupied_q;
    mul_stage_pack_t pack_d;
    mul_stage_pack_t pack_q;

    always_comb begin
        occupied_d = occupied_q;
        pack_d     = pack_q;
        if (advance) begin
            occupied_d = in_occupied;
            pack_d     = in_pack;
        end
        // A flush only has to kill the occupied bit; the stale payload is never observed.
        if (clear) begin
            occupied_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            occupied_q <= 1'b0;
            pack_q     <= '0;
        end else begin
            occupied_q <= occupied_d;
            pack_q     <= pack_d;
        end
    end

    assign out_occupied = occupied_q;
    assign out_pack     = pack_q;
endmodule

// File: rtl/execute_mul.sv
// rtl/execute_mul.sv - pipelined RV multiply unit between the issue FIFO and writeback port
module execute_mul import execute_mul_pkg::*; #(
    parameter int LATENCY         = 3,
    parameter int FEEDBACK_ENABLE = 1
) (
    input  logic          clk,
    input  logic          rst,
    execute_mul_if.master bus
);
    issue_execute_pack_t       head;
    logic                      commit_flush;
    logic                      advance;
    logic                      pop;
    logic                      load_occupied;
    mul_stage_pack_t           load_pack;
    logic [LATENCY-1:0]        stage_occupied;
    mul_stage_pack_t           stage_pack [LATENCY];
    mul_stage_pack_t           last;
    logic                      last_occupied;
    logic                      pipe_empty;
    logic                      we;
    execute_wb_pack_t          wb_pack;
    execute_feedback_channel_t fb_pack;

    assign head          = bus.issue_mul_fifo_data_out;
    assign last          = stage_pack[LATENCY-1];
    assign last_occupied = stage_occupied[LATENCY-1];
    assign pipe_empty    = ~|stage_occupied;

    always_comb begin
        commit_flush = bus.commit_feedback_pack.enable && bus.commit_feedback_pack.flush;
        advance      = !last_occupied || !bus.mul_wb_port_full;
        // rst gates pop so the FIFO is never drained while the pipeline is held in reset.
        pop          = rst && bus.issue_mul_fifo_data_out_valid && advance && !commit_flush;
        load_occupied = pop && head.enable;

        load_pack                 = '0;
        load_pack.valid           = head.valid;
        load_pack.rob_id          = head.rob_id;
        load_pack.pc              = head.pc;
        load_pack.rd              = head.rd;
        load_pack.rd_enable       = head.rd_enable;
        load_pack.need_rename     = head.need_rename;
        load_pack.rd_phy          = head.rd_phy;
        load_pack.has_exception   = !head.valid || head.has_exception;
        load_pack.exception_id    = head.valid ? head.exception_id : illegal_instruction;
        load_pack.exception_value = head.exception_value;
        load_pack.sub_op          = head.sub_op.mul_op;
        load_pack.product         = mul_product(head.sub_op.mul_op, head.src1_value,
                                                head.src2_value);
    end

    for (genvar i = 0; i < LATENCY; i++) begin : g_stage
        logic            in_occupied;
        mul_stage_pack_t in_pack;

        if (i == 0) begin : g_head
            assign in_occupied = load_occupied;
            assign in_pack     = load_pack;
        end else begin : g_link
            assign in_occupied = stage_occupied[i-1];
            assign in_pack     = stage_pack[i-1];
        end

        execute_mul_stage u_stage (
            .clk          (clk),
            .rst          (rst),
            .advance      (advance),
            .clear        (commit_flush),
            .in_occupied  (in_occupied),
            .in_pack      (in_pack),
            .out_occupied (stage_occupied[i]),
            .out_pack     (stage_pack[i])
        );
    end

    always_comb begin
        we = last_occupied && !bus.mul_wb_port_full && !commit_flush;

        wb_pack                 = '0;
        wb_pack.enable          = last_occupied;
        wb_pack.valid           = last.valid;
        wb_pack.rob_id          = last.rob_id;
        wb_pack.pc              = last.pc;
        wb_pack.rd              = last.rd;
        wb_pack.rd_enable       = last.rd_enable;
        wb_pack.need_rename     = last.need_rename;
        wb_pack.rd_phy          = last.rd_phy;
        wb_pack.rd_value        = last.has_exception ? '0 : mul_select(last.sub_op, last.product);
        wb_pack.has_exception   = last.has_exception;
        wb_pack.exception_id    = last.exception_id;
        wb_pack.exception_value = last.exception_value;

        fb_pack        = '0;
        fb_pack.enable = (FEEDBACK_ENABLE != 0) && we && last.valid && !last.has_exception &&
                         last.rd_enable && last.need_rename;
        fb_pack.phy_id = wb_pack.rd_phy;
        fb_pack.value  = wb_pack.rd_value;

        bus.issue_mul_fifo_pop                = pop;
        bus.mul_wb_port_data_in               = wb_pack;
        bus.mul_wb_port_we                    = we;
        bus.mul_wb_port_flush                 = commit_flush || pipe_empty;
        bus.mul_execute_channel_feedback_pack = fb_pack;
    end
endmodule

// File: doc/execute_mul.md
EXECUTE_MUL -- requirements
Module: execute_mul

Interface
REQ-001 Parameter LATENCY, default 3, pipeline depth in stages from FIFO pop to writeback presentation, legal range 1..8.
REQ-002 Parameter FEEDBACK_ENABLE, default 1, when 0 the feedback channel enable is tied low.
REQ-003 clk  input  1  single clock; all state updates on posedge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 issue_mul_fifo_data_out  input  issue_execute_pack_t  head entry of the issue-to-mul FIFO.
REQ-006 issue_mul_fifo_data_out_valid  input  1  FIFO head holds an entry.
REQ-007 issue_mul_fifo_pop  output  1  consume the FIFO head this cycle.
REQ-008 mul_wb_port_data_in  output  execute_wb_pack_t  result pack toward the writeback port.
REQ-009 mul_wb_port_we  output  1  write mul_wb_port_data_in this cycle.
REQ-010 mul_wb_port_full  input  1  writeback port cannot accept a write this cycle.
REQ-011 mul_wb_port_flush  output  1  clear the writeback port.
REQ-012 mul_execute_channel_feedback_pack  output  execute_feedback_channel_t  bypass of the result to waiting consumers.
REQ-013 commit_feedback_pack  input  commit_feedback_pack_t  commit-stage status; flush is honoured only when enable=1.

Function
REQ-014 Pipeline SHALL hold LATENCY stage registers, each with an occupied bit and a carried pack (execute_wb_pack_t fields plus a 2*XLEN product).
REQ-015 advance = !stage[LATENCY-1].occupied || !mul_wb_port_full; all stages SHALL shift by one when advance=1 and hold otherwise.
REQ-016 issue_mul_fifo_pop = issue_mul_fifo_data_out_valid && advance && !commit_flush, where commit_flush = commit_feedback_pack.enable && commit_feedback_pack.flush.
REQ-017 Stage 0 SHALL load the popped entry. An entry with enable=0 SHALL load as unoccupied.
REQ-018 Product SHALL be computed at stage-0 load from src1_value/src2_value. mul gives the low XLEN bits. mulh gives the high XLEN bits of signed*signed. mulhsu gives the high XLEN bits of signed*unsigned. mulhu gives the high XLEN bits of unsigned*unsigned.
REQ-019 Entry with valid=0 SHALL emerge with valid=0, has_exception=1, exception_id=illegal_instruction.
REQ-020 Entry with has_exception=1 SHALL pass exception_id and exception_value through unchanged, and rd_value SHALL be 0.
REQ-021 rob_id, pc, rd, rd_phy, rd_enable and need_rename SHALL pass through unchanged.
REQ-022 mul_wb_port_data_in SHALL be driven from stage[LATENCY-1]. mul_wb_port_we = stage[LATENCY-1].occupied && !mul_wb_port_full && !commit_flush.
REQ-023 Feedback enable SHALL equal mul_wb_port_we && valid && !has_exception && rd_enable && need_rename. phy_id SHALL be rd_phy and value SHALL be rd_value.
REQ-024 Latency SHALL be exactly LATENCY cycles from the pop edge to we=1 when no stall occurs. Throughput SHALL be one result per cycle.
REQ-025 On commit_flush, pop and we SHALL be 0 and mul_wb_port_flush SHALL be 1 in the same cycle, and all occupied bits SHALL clear at the next edge.
REQ-026 When the pipeline is empty and no commit_flush is present, mul_wb_port_flush SHALL be 1.
REQ-027 When mul_wb_port_full=1 and the final stage is occupied, the pipeline SHALL freeze with no pop, no loss and no duplication.
REQ-028 When FIFO valid and wb full occur together with the pipeline full, pop SHALL be 0.

Reset
REQ-029 While rst=0, all occupied bits SHALL be 0, pop=0, we=0, mul_wb_port_flush=1, feedback enable=0 and mul_wb_port_data_in.enable=0.
REQ-030 Reset asserted mid-operation SHALL discard all in-flight entries immediately and asynchronously.

Structure
REQ-031 mul_op_t (mul, mulh, mulhsu, mulhu) SHALL be defined in the shared common package as a sub_op member, alongside the existing alu_op_t.
REQ-032 XLEN SHALL come from config.svh. No new constants SHALL be added locally beyond LATENCY and FEEDBACK_ENABLE.
REQ-033 One sub-module, execute_mul_stage, SHALL implement a single stall-able pipeline register and be instantiated LATENCY times via generate.

Verification
REQ-034 Reset release with FIFO empty -> we=0, flush=1, pop=0, feedback.enable=0.
REQ-035 LATENCY=3, mul with 5*6, rd_phy=10, rd_enable=1, need_rename=1 -> pop in cycle 0; we=1 and rd_value=30 in cycle 3; feedback phy_id=10, value=30.
REQ-036 mulh 0xFFFFFFFF*0xFFFFFFFF -> 0; mulhu with the same operands -> 0xFFFFFFFE; mulhsu 0xFFFFFFFF*2 -> 0xFFFFFFFF.
REQ-037 Back-to-back 4 entries, wb_full held high for 2 cycles on the first result -> pop=0 while frozen; 4 results emerge in order with none lost or duplicated.
REQ-038 valid=0 entry -> has_exception=1, illegal_instruction, feedback.enable=0.
REQ-039 commit flush with 2 entries in flight -> that cycle we=0, flush=1, pop=0; next cycle the pipeline is empty and no stale result appears.
